// File: rtl/fetch_pc_ctrl.sv
// Fetch-PC sequencer: owns the fetch PC, issues one 2-instruction I-cache
// request per cycle, applies redirect/prediction priority and drains stale
// I-cache responses after a redirect.
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int unsigned MAX_OUT  = 2,
    parameter int unsigned EPOCH_W  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               except_valid,
    input  logic [31:0]        except_pc,
    input  logic               bru_redirect_valid,
    input  logic [31:0]        bru_redirect_pc,
    input  logic               bpu_taken,
    input  logic [31:0]        bpu_target,
    input  logic               fetch_stall,
    output logic               icache_req_valid,
    output logic [31:0]        icache_req_pc,
    input  logic               icache_req_ready,
    input  logic               icache_resp_valid,
    output logic               resp_keep,
    output logic [EPOCH_W-1:0] fetch_epoch
);

    localparam int unsigned CW = $clog2(MAX_OUT + 1);

    typedef enum logic {
        RUN,
        DRAIN
    } state_t;

    state_t             state, state_next;
    logic [31:0]        pc, pc_next;
    logic [EPOCH_W-1:0] epoch, epoch_next;
    logic [CW-1:0]      out_cnt, cnt_next;
    logic [CW-1:0]      settle;
    logic               redirect;
    logic [31:0]        redirect_pc;
    logic               accept;
    logic               settled;

    assign settled = (settle == CW'(MAX_OUT));

    // Redirect selection, request gating and next-state/next-PC computation.
    always_comb begin
        redirect    = except_valid | bru_redirect_valid;
        redirect_pc = except_valid ? except_pc : bru_redirect_pc;

        icache_req_valid = (state == RUN) & ~fetch_stall &
                           (out_cnt < CW'(MAX_OUT)) & ~redirect;
        icache_req_pc    = pc;
        accept           = icache_req_valid & icache_req_ready;
        resp_keep        = icache_resp_valid & (state == RUN) & ~redirect;
        fetch_epoch      = epoch;

        // Accept and response together leave the count unchanged; a response
        // with nothing outstanding saturates at zero.
        cnt_next = out_cnt;
        if (accept && !icache_resp_valid) begin
            cnt_next = out_cnt + CW'(1);
        end else if (!accept && icache_resp_valid && out_cnt != '0) begin
            cnt_next = out_cnt - CW'(1);
        end

        pc_next = pc;
        if (redirect) begin
            pc_next = redirect_pc;
        end else if (accept && bpu_taken) begin
            pc_next = bpu_target;
        end else if (accept) begin
            pc_next = pc + (pc[2] ? 32'd4 : 32'd8);
        end

        epoch_next = redirect ? epoch + EPOCH_W'(1) : epoch;

        state_next = state;
        case (state)
            RUN: begin
                if (redirect && cnt_next != '0) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt_next == '0) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RUN;
            pc      <= RESET_PC;
            epoch   <= '0;
            out_cnt <= '0;
            settle  <= '0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            epoch   <= epoch_next;
            out_cnt <= cnt_next;
            if (!settled) begin
                settle <= settle + CW'(1);
            end
        end
    end

    // Protocol check: a response with no outstanding request, once settled after reset.
    always_ff @(posedge clk) begin
        if (!reset && settled) begin
            assert (!(icache_resp_valid && out_cnt == '0));
        end
    end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Scoreboard bench for fetch_pc_ctrl: stimulus pushes expected requests,
// responses and snapshots; the monitor pops and compares on the falling edge.
module tb_fetch_pc_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        except_valid = 1'b0;
    logic [31:0] except_pc = '0;
    logic        bru_redirect_valid = 1'b0;
    logic [31:0] bru_redirect_pc = '0;
    logic        bpu_taken = 1'b0;
    logic [31:0] bpu_target = '0;
    logic        fetch_stall = 1'b0;
    logic        icache_req_valid;
    logic [31:0] icache_req_pc;
    logic        icache_req_ready = 1'b0;
    logic        icache_resp_valid = 1'b0;
    logic        resp_keep;
    logic [2:0]  fetch_epoch;

    typedef struct {
        logic [31:0] pc;
        logic [2:0]  ep;
    } req_t;

    req_t req_q[$];
    bit   keep_q[$];

    // snapshot expectation for the current cycle
    bit          snap_en = 1'b0;
    logic        snap_valid;
    logic [31:0] snap_pc;
    logic [2:0]  snap_ep;
    logic        snap_keep;

    bit done = 1'b0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fetch_pc_ctrl #(
        .RESET_PC(32'hBFC0_0000),
        .MAX_OUT (2),
        .EPOCH_W (3)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .except_valid      (except_valid),
        .except_pc         (except_pc),
        .bru_redirect_valid(bru_redirect_valid),
        .bru_redirect_pc   (bru_redirect_pc),
        .bpu_taken         (bpu_taken),
        .bpu_target        (bpu_target),
        .fetch_stall       (fetch_stall),
        .icache_req_valid  (icache_req_valid),
        .icache_req_pc     (icache_req_pc),
        .icache_req_ready  (icache_req_ready),
        .icache_resp_valid (icache_resp_valid),
        .resp_keep         (resp_keep),
        .fetch_epoch       (fetch_epoch)
    );

    // Monitor: all comparisons and counting happen here.
    always @(negedge clk) begin
        if (done) begin
            total++;
            if (req_q.size() != 0) begin
                bad++;
                $display("FAIL req_drain: %0d requests expected but never issued", req_q.size());
            end
            total++;
            if (keep_q.size() != 0) begin
                bad++;
                $display("FAIL resp_drain: %0d responses expected but never seen", keep_q.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end else if (!reset) begin
            if (snap_en) begin
                total++;
                if (icache_req_valid !== snap_valid || icache_req_pc !== snap_pc ||
                    fetch_epoch !== snap_ep || resp_keep !== snap_keep) begin
                    bad++;
                    $display("FAIL snapshot: got valid=%b pc=%h ep=%0d keep=%b want valid=%b pc=%h ep=%0d keep=%b",
                             icache_req_valid, icache_req_pc, fetch_epoch, resp_keep,
                             snap_valid, snap_pc, snap_ep, snap_keep);
                end
            end
            if (icache_req_valid && icache_req_ready) begin
                total++;
                if (req_q.size() == 0) begin
                    bad++;
                    $display("FAIL req_unexpected: got pc=%h ep=%0d want no request",
                             icache_req_pc, fetch_epoch);
                end else begin
                    req_t e;
                    e = req_q.pop_front();
                    if (icache_req_pc !== e.pc || fetch_epoch !== e.ep) begin
                        bad++;
                        $display("FAIL req: got pc=%h ep=%0d want pc=%h ep=%0d",
                                 icache_req_pc, fetch_epoch, e.pc, e.ep);
                    end
                end
            end
            if (icache_resp_valid) begin
                total++;
                if (keep_q.size() == 0) begin
                    bad++;
                    $display("FAIL resp_unexpected: got keep=%b want no response", resp_keep);
                end else begin
                    bit k;
                    k = keep_q.pop_front();
                    if (resp_keep !== k) begin
                        bad++;
                        $display("FAIL resp_keep: got %b want %b", resp_keep, k);
                    end
                end
            end
        end
    end

    task automatic snap(input logic v, input logic [31:0] pc, input logic [2:0] ep, input logic k);
        snap_en    = 1'b1;
        snap_valid = v;
        snap_pc    = pc;
        snap_ep    = ep;
        snap_keep  = k;
    endtask

    // Push expectations for this cycle, advance one clock, then idle inputs.
    task automatic tick(input bit er, input logic [31:0] pc, input logic [2:0] ep,
                        input bit eresp, input bit keep);
        if (er) req_q.push_back('{pc, ep});
        if (eresp) keep_q.push_back(keep);
        @(posedge clk);
        #1;
        snap_en            = 1'b0;
        except_valid       = 1'b0;
        bru_redirect_valid = 1'b0;
        bpu_taken          = 1'b0;
        fetch_stall        = 1'b0;
        icache_req_ready   = 1'b0;
        icache_resp_valid  = 1'b0;
    endtask

    initial begin
        tick(0, '0, '0, 0, 0);
        tick(0, '0, '0, 0, 0);
        reset = 1'b0;

        // sequential fetch, one response per cycle
        icache_req_ready = 1; snap(1, 32'hBFC00000, 0, 0);
        tick(1, 32'hBFC00000, 0, 0, 0);
        icache_req_ready = 1; icache_resp_valid = 1;
        tick(1, 32'hBFC00008, 0, 1, 1);
        icache_req_ready = 1; icache_resp_valid = 1;
        tick(1, 32'hBFC00010, 0, 1, 1);
        icache_resp_valid = 1; snap(1, 32'hBFC00018, 0, 1);
        tick(0, '0, '0, 1, 1);
        fetch_stall = 1; icache_req_ready = 1; snap(0, 32'hBFC00018, 0, 0);
        tick(0, '0, '0, 0, 0);
        icache_req_ready = 1;
        tick(1, 32'hBFC00018, 0, 0, 0);

        // reset with a request outstanding
        reset = 1'b1; icache_req_ready = 1;
        tick(0, '0, '0, 0, 0);
        reset = 1'b0;

        // taken prediction on the accept of BFC00008
        icache_req_ready = 1; snap(1, 32'hBFC00000, 0, 0);
        tick(1, 32'hBFC00000, 0, 0, 0);
        icache_req_ready = 1; icache_resp_valid = 1; bpu_taken = 1; bpu_target = 32'h80001000;
        tick(1, 32'hBFC00008, 0, 1, 1);
        icache_req_ready = 1; icache_resp_valid = 1;
        tick(1, 32'h80001000, 0, 1, 1);

        // fill to MAX_OUT, then free one slot
        icache_req_ready = 1;
        tick(1, 32'h80001008, 0, 0, 0);
        icache_req_ready = 1; snap(0, 32'h80001010, 0, 0);
        tick(0, '0, '0, 0, 0);
        icache_req_ready = 1; icache_resp_valid = 1; snap(0, 32'h80001010, 0, 1);
        tick(0, '0, '0, 1, 1);
        icache_req_ready = 1; snap(1, 32'h80001010, 0, 0);
        tick(1, 32'h80001010, 0, 0, 0);

        // redirect with two outstanding: drain both, then fetch target
        icache_req_ready = 1; bru_redirect_valid = 1; bru_redirect_pc = 32'h80000200;
        snap(0, 32'h80001018, 0, 0);
        tick(0, '0, '0, 0, 0);
        icache_req_ready = 1; icache_resp_valid = 1; snap(0, 32'h80000200, 1, 0);
        tick(0, '0, '0, 1, 0);
        icache_req_ready = 1; icache_resp_valid = 1;
        tick(0, '0, '0, 1, 0);
        icache_req_ready = 1; snap(1, 32'h80000200, 1, 0);
        tick(1, 32'h80000200, 1, 0, 0);

        // redirect coinciding with a response: response dropped, unaligned target
        icache_req_ready = 1; icache_resp_valid = 1;
        bru_redirect_valid = 1; bru_redirect_pc = 32'h80000004;
        tick(0, '0, '0, 1, 0);
        icache_req_ready = 1; snap(1, 32'h80000004, 2, 0);
        tick(1, 32'h80000004, 2, 0, 0);
        icache_req_ready = 1; icache_resp_valid = 1;
        tick(1, 32'h80000008, 2, 1, 1);
        icache_resp_valid = 1;
        tick(0, '0, '0, 1, 1);

        // exception and mispredict together: exception wins, epoch +1 once
        icache_req_ready = 1; except_valid = 1; except_pc = 32'h80000180;
        bru_redirect_valid = 1; bru_redirect_pc = 32'h80000400;
        snap(0, 32'h80000010, 2, 0);
        tick(0, '0, '0, 0, 0);
        icache_req_ready = 1; snap(1, 32'h80000180, 3, 0);
        tick(1, 32'h80000180, 3, 0, 0);
        icache_resp_valid = 1; snap(1, 32'h80000188, 3, 1);
        tick(0, '0, '0, 1, 1);

        // back-to-back redirects: epoch 3..7 then wraps to 0
        for (int i = 0; i < 5; i++) begin
            logic [31:0] prev_pc;
            logic [2:0]  ep_now;
            prev_pc = (i == 0) ? 32'h80000188 : 32'h80002000 + 32'(16 * (i - 1));
            ep_now  = 3'(3 + i);
            bru_redirect_valid = 1; bru_redirect_pc = 32'h80002000 + 32'(16 * i);
            snap(0, prev_pc, ep_now, 0);
            tick(0, '0, '0, 0, 0);
        end
        icache_req_ready = 1; snap(1, 32'h80002040, 0, 0);
        tick(1, 32'h80002040, 0, 0, 0);
        icache_resp_valid = 1;
        tick(0, '0, '0, 1, 1);

        tick(0, '0, '0, 0, 0);
        tick(0, '0, '0, 0, 0);
        done = 1'b1;
        tick(0, '0, '0, 0, 0);
        tick(0, '0, '0, 0, 0);
        $display("FAIL timeout: monitor did not finish");
        $fatal(1);
    end

endmodule
